// File: rtl/result_packer_pkg.sv
// Shared constants, the FIFO entry layout and the packer state encoding.
package result_packer_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int WORD_W           = 32;
  localparam int COUNT_W          = 4;

  // One queued word together with the number of valid nibbles it carries.
  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic [WORD_W-1:0]  data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } pack_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of packed words; head is shown combinationally, zero when empty.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_valid = (level != '0);
  assign full       = (level == FULL_LVL);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage array write.
  // NOTE: the storage array has no reset; validity comes from the level counter, and
  // an unreset array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop && !head_valid));
  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/result_packer.sv
// Packs 4-lane result nibbles into 32-bit words and queues them with a nibble count.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [0:3]             in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WORD_W-1:0]      out_data,
  output logic [COUNT_W-1:0]     out_count,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level
);

  pack_state_e        state_q, state_d;
  logic [2:0]         nib_cnt_q;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  word_ins;
  logic [COUNT_W-1:0] cnt_after;
  logic               accept, flush_req, full_push, flush_push, flush_block;
  logic               push, pop, fifo_full;
  entry_t             push_entry, head_entry;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a push always empties the packer; a flush blocked by a full FIFO waits.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (full_push || flush_push)            state_d = ST_IDLE;
    else if (flush_block)                   state_d = ST_FLUSH_WAIT;
    else if (cnt_after != '0)               state_d = ST_FILL;
    else                                    state_d = ST_IDLE;
  end

  // Outputs and push decode; in_ready uses registered state only, never out_ready.
  always_comb begin
    in_ready = (state_q != ST_FLUSH_WAIT) && !((nib_cnt_q == 3'd7) && fifo_full);
    accept   = in_valid && in_ready;
    word_ins = word_q;
    if (accept) word_ins[{nib_cnt_q, 2'b00} +: 4] = in_data;
    cnt_after   = {1'b0, nib_cnt_q} + {3'b000, accept};
    flush_req   = flush || (state_q == ST_FLUSH_WAIT);
    full_push   = accept && (nib_cnt_q == 3'd7);
    flush_push  = !full_push && flush_req && (cnt_after != '0) && !fifo_full;
    flush_block = !full_push && flush_req && (cnt_after != '0) && fifo_full;
    push        = full_push || flush_push;
    push_entry  = '{count: cnt_after, data: word_ins};
    pop         = out_valid && out_ready;
  end

  // Partial word and nibble counter; both clear whenever a word leaves for the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      nib_cnt_q <= '0;
      word_q    <= '0;
    end else if (push) begin
      nib_cnt_q <= '0;
      word_q    <= '0;
    end else if (accept) begin
      nib_cnt_q <= cnt_after[2:0];
      word_q    <= word_ins;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (out_valid),
    .full       (fifo_full),
    .level      (fifo_level)
  );

  assign out_data  = head_entry.data;
  assign out_count = head_entry.count;

endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer with DEPTH=4.
module tb_result_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [0:3]  in_data = 4'h0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_count;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  result_packer #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one nibble, waiting (bounded) for in_ready, then deassert valid.
  task automatic send_nib(input logic [3:0] n);
    int wait_cyc = 0;
    in_valid = 1'b1;
    in_data  = n;
    while (!in_ready && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_nib timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_nib(4'(i));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL full_data: got %h want 87654321", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", out_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_popped: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_partial();
    send_nib(4'hA); send_nib(4'hB); send_nib(4'hC);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_no_word: got %b want 0", out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h00000CBA) begin errors++; $display("FAIL partial_data: got %h want 00000cba", out_data); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL partial_count: got %0d want 3", out_count); end
    checks++; if (dut.nib_cnt_q !== 3'd0) begin errors++; $display("FAIL partial_nib_cnt: got %0d want 0", dut.nib_cnt_q); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_popped: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_with_nibble();
    send_nib(4'h1); send_nib(4'h2);
    in_valid = 1'b1; in_data = 4'h3; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_data !== 32'h00000321) begin errors++; $display("FAIL flushnib_data: got %h want 00000321", out_data); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL flushnib_count: got %0d want 3", out_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush_with_eighth();
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send_nib(4'(i));
    in_valid = 1'b1; in_data = 4'h8; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL eighth_data: got %h want 87654321", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL eighth_count: got %0d want 8", out_count); end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eighth_extra_word: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eighth_pending: in_ready %b want 1", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_word: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_flush_pending: in_ready %b want 1", in_ready); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL empty_flush_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [5];
    int k = 0;
    logic acc;
    exp_w = '{32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98, 32'h76543210};
    out_ready = 1'b0;
    for (int i = 0; i < 39; i++) send_nib(4'(i & 15));
    in_valid = 1'b1; in_data = 4'h7;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (dut.nib_cnt_q !== 3'd7) begin errors++; $display("FAIL bp_nib_cnt: got %0d want 7", dut.nib_cnt_q); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== exp_w[k] || out_count !== 4'd8) begin
          errors++;
          $display("FAIL bp_word%0d: got %h/%0d want %h/8", k, out_data, out_count, exp_w[k]);
        end
        k++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (k != 5) begin errors++; $display("FAIL bp_drain_count: got %0d words want 5", k); end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush_when_full();
    logic [31:0] exp_w [4];
    logic [3:0]  exp_c [4];
    int k = 0;
    exp_w = '{32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98, 32'h00000095};
    exp_c = '{4'd8, 4'd8, 4'd8, 4'd2};
    for (int i = 0; i < 32; i++) send_nib(4'(i & 15));
    send_nib(4'h5); send_nib(4'h9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ff_in_ready: got %b want 0", in_ready); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ff_level: got %0d want 4", fifo_level); end
    checks++; if (out_data !== 32'h76543210) begin errors++; $display("FAIL ff_head: got %h want 76543210", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ff_refill: got %0d want 4", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ff_released: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== exp_w[k] || out_count !== exp_c[k]) begin
          errors++;
          $display("FAIL ff_word%0d: got %h/%0d want %h/%0d", k, out_data, out_count, exp_w[k], exp_c[k]);
        end
        k++;
      end
      step();
    end
    checks++; if (k != 4) begin errors++; $display("FAIL ff_drain_count: got %0d words want 4", k); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 21; i++) send_nib(4'hE);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL rst_pre_level: got %0d want 2", fifo_level); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_nib(4'(i));
    checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL rst_clean_data: got %h want 87654321", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL rst_clean_count: got %0d want 8", out_count); end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_with_nibble();
    test_flush_with_eighth();
    test_flush_empty();
    test_backpressure();
    test_flush_when_full();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-002 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port in_valid, input, 1: in_data carries a 4-lane result this cycle.
REQ-005 Port in_data, input, [0:3]: per-lane result bits from the upstream 4-instance array; in_data[0] is lane 0.
REQ-006 Port in_ready, output, 1: a nibble is accepted when in_valid && in_ready.
REQ-007 Port flush, input, 1: single-cycle pulse requesting emission of a partially filled word.
REQ-008 Port out_valid, output, 1: FIFO head is valid.
REQ-009 Port out_data, output, 32: packed word at the FIFO head.
REQ-010 Port out_count, output, 4: number of valid nibbles in out_data, 1..8.
REQ-011 Port out_ready, input, 1: the head word is popped when out_valid && out_ready.
REQ-012 Port fifo_level, output, clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-013 Nibble k of a word (k = 0..7, in acceptance order) shall occupy out_data[4k+3:4k], with in_data[i] mapped to bit 4k+(3-i).
REQ-014 A packer counter nib_cnt (0..7) shall increment on each accepted nibble.
REQ-015 On acceptance with nib_cnt==7, the completed word with count 8 shall be pushed to the FIFO in the same edge, and nib_cnt shall return to 0.
REQ-016 A pushed word shall be visible on out_valid/out_data the cycle after the push edge, giving 1-cycle latency when the FIFO is empty.
REQ-017 in_ready shall be low only when nib_cnt==7, the FIFO is full, or a flush is pending; in_ready shall not depend combinationally on out_ready.
REQ-018 A simultaneous push and pop shall be allowed at any level, including full; the level shall stay unchanged.
REQ-019 Flush shall set a flush_pending flag; when nib_cnt>0 and the FIFO has space, the partial word shall be pushed with zero-padded upper nibbles and out_count=nib_cnt, nib_cnt shall clear, and flush_pending shall clear.
REQ-020 Flush with in_valid && in_ready in the same cycle shall include that nibble in the flushed word; a flush arriving together with the 8th nibble shall produce only the full word.
REQ-021 Flush with nib_cnt==0 and no nibble accepted shall have no effect and shall leave no pending flag.
REQ-022 FIFO read and write pointers shall wrap modulo DEPTH; a pop on empty and a push on full without a pop are impossible by construction and shall be asserted against.
REQ-023 Packer state machine: states IDLE (nib_cnt==0), FILL (0<nib_cnt), and FLUSH_WAIT (flush_pending with FIFO full).
REQ-024 Packer transitions: IDLE->FILL on an accepted nibble; FILL->IDLE on a full push or a flush push; FILL->FLUSH_WAIT on flush with the FIFO full; FLUSH_WAIT->IDLE when the partial word is pushed.

Reset
REQ-025 On reset, nib_cnt, flush_pending, the FIFO pointers and fifo_level shall clear to 0, out_valid shall be 0, and in_ready shall be 1.
REQ-026 On reset, out_data and out_count shall read 0; the partial word register shall clear.
REQ-027 Reset asserted mid-word or mid-flush shall discard all partial and queued data with no push.

Structure
REQ-028 Package result_packer_pkg shall hold NIBBLES_PER_WORD=8, WORD_W=32, COUNT_W=4 and the packer state enum.
REQ-029 The FIFO shall be a sub-module result_fifo parameterised on DEPTH and entry width 36 (data plus count).

Verification
REQ-030 8 nibbles 0x1..0x8 back-to-back, out_ready=1 -> one word 0x87654321 with count 8, out_valid the cycle after the 8th accept.
REQ-031 3 nibbles 0xA,0xB,0xC then flush -> word 0x00000CBA with count 3; nib_cnt back to 0.
REQ-032 out_ready=0, stream 40 nibbles with DEPTH=4 -> fifo_level reaches 4, in_ready low with nib_cnt==7; release out_ready -> words drain in order with no loss.
REQ-033 Flush while the FIFO is full with nib_cnt=2 -> in_ready low; after one pop, the partial word is pushed with count 2.
REQ-034 Reset asserted after 5 nibbles with 2 words queued -> out_valid=0 and fifo_level=0 next cycle; next 8 nibbles form a clean word.
REQ-035 Flush with nib_cnt==0 -> no word emitted and no pending state.
